// File: rtl/mem_pkg.sv
// Shared widths and arbiter state encoding for the memory stage.
package mem_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 16;
    localparam int REG_W_DEF  = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        HOLD1 = 1'b1
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Two-lane arbiter in front of a single-port data memory.
// Lane 0 is older; a lane-1 request that loses arbitration is served next cycle.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              l0_valid,
    output logic              l0_ready,
    input  logic [ADDR_W-1:0] l0_addr,
    input  logic [DATA_W-1:0] l0_value,
    input  logic              l0_is_load,
    input  logic              l0_is_mem_write,
    input  logic              l0_is_write,
    input  logic [REG_W-1:0]  l0_reg,
    input  logic              l1_valid,
    output logic              l1_ready,
    input  logic [ADDR_W-1:0] l1_addr,
    input  logic [DATA_W-1:0] l1_value,
    input  logic              l1_is_load,
    input  logic              l1_is_mem_write,
    input  logic              l1_is_write,
    input  logic [REG_W-1:0]  l1_reg,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_valid,
    output logic              wb_lane,
    output logic [REG_W-1:0]  wb_reg,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_we
);

    arb_state_e state;

    logic              grant0;
    logic              grant1;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_value;
    logic              sel_load;
    logic              sel_mwr;
    logic              sel_wr;
    logic [REG_W-1:0]  sel_reg;
    logic [DATA_W-1:0] sel_result;

    // Reset and flush both suppress any grant in the current cycle.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst && !flush) begin
            if (state == HOLD1) begin
                grant1 = l1_valid;
            end else begin
                grant0 = l0_valid;
                grant1 = !l0_valid && l1_valid;
            end
        end
    end

    assign l0_ready = grant0;
    assign l1_ready = grant1;

    always_comb begin
        sel_addr  = '0;
        sel_value = '0;
        sel_load  = 1'b0;
        sel_mwr   = 1'b0;
        sel_wr    = 1'b0;
        sel_reg   = '0;
        unique case (1'b1)
            grant0: begin
                sel_addr  = l0_addr;
                sel_value = l0_value;
                sel_load  = l0_is_load;
                sel_mwr   = l0_is_mem_write;
                sel_wr    = l0_is_write;
                sel_reg   = l0_reg;
            end
            grant1: begin
                sel_addr  = l1_addr;
                sel_value = l1_value;
                sel_load  = l1_is_load;
                sel_mwr   = l1_is_mem_write;
                sel_wr    = l1_is_write;
                sel_reg   = l1_reg;
            end
            default: ;
        endcase
    end

    assign mem_addr  = sel_addr;
    assign mem_wdata = sel_value;
    assign mem_we    = sel_mwr;

    // A store flagged as a load still writes back its own value.
    assign sel_result = (sel_load && !sel_mwr) ? mem_rdata : sel_value;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wb_valid <= 1'b0;
            wb_lane  <= 1'b0;
            wb_reg   <= '0;
            wb_data  <= '0;
            wb_we    <= 1'b0;
        end else begin
            if (!flush && state == IDLE && l0_valid && l1_valid) begin
                state <= HOLD1;
            end else begin
                state <= IDLE;
            end
            if (grant0 || grant1) begin
                wb_valid <= 1'b1;
                wb_lane  <= grant1;
                wb_reg   <= sel_reg;
                wb_data  <= sel_result;
                wb_we    <= sel_wr;
            end else begin
                wb_valid <= 1'b0;
                wb_we    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a
// transaction-level reference model with its own copy of memory.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        l0_valid, l1_valid;
    logic        l0_ready, l1_ready;
    logic [4:0]  l0_addr, l1_addr;
    logic [15:0] l0_value, l1_value;
    logic        l0_is_load, l1_is_load;
    logic        l0_is_mem_write, l1_is_mem_write;
    logic        l0_is_write, l1_is_write;
    logic [2:0]  l0_reg, l1_reg;
    logic [4:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic [15:0] mem_rdata;
    logic        wb_valid, wb_lane, wb_we;
    logic [2:0]  wb_reg;
    logic [15:0] wb_data;

    int errors = 0;
    int checks = 0;
    bit rand_on = 1'b0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst), .flush(flush),
        .l0_valid(l0_valid), .l0_ready(l0_ready), .l0_addr(l0_addr),
        .l0_value(l0_value), .l0_is_load(l0_is_load),
        .l0_is_mem_write(l0_is_mem_write), .l0_is_write(l0_is_write),
        .l0_reg(l0_reg),
        .l1_valid(l1_valid), .l1_ready(l1_ready), .l1_addr(l1_addr),
        .l1_value(l1_value), .l1_is_load(l1_is_load),
        .l1_is_mem_write(l1_is_mem_write), .l1_is_write(l1_is_write),
        .l1_reg(l1_reg),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_lane(wb_lane), .wb_reg(wb_reg),
        .wb_data(wb_data), .wb_we(wb_we)
    );

    function automatic logic [15:0] init_word(input int i);
        return 16'(i * 16'h0101) ^ 16'h5A5A;
    endfunction

    // External data memory, reloaded with a known pattern on reset.
    logic [15:0] phys_mem [32];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) phys_mem[i] <= init_word(i);
        end else if (mem_we) begin
            phys_mem[mem_addr] <= mem_wdata;
        end
    end
    assign mem_rdata = phys_mem[mem_addr];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input int n, input logic v, input logic [4:0] a,
                         input logic [15:0] d, input logic ld, input logic mw,
                         input logic wr, input logic [2:0] r);
        if (n == 0) begin
            l0_valid = v; l0_addr = a; l0_value = d; l0_is_load = ld;
            l0_is_mem_write = mw; l0_is_write = wr; l0_reg = r;
        end else begin
            l1_valid = v; l1_addr = a; l1_value = d; l1_is_load = ld;
            l1_is_mem_write = mw; l1_is_write = wr; l1_reg = r;
        end
    endtask

    task automatic idle(input int n);
        drive(n, 1'b0, 5'd0, 16'd0, 1'b0, 1'b0, 1'b0, 3'd0);
    endtask

    task automatic rand_lane(input int n);
        drive(n, 1'b1, 5'($urandom_range(0, 31)), 16'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference model: a lane-1 request that lost to lane 0 is owed the
    // next cycle; memory contents are tracked independently of the DUT.
    logic [15:0] ref_mem [32];
    logic        owe1;
    logic        e_valid, e_lane, e_we;
    logic [2:0]  e_reg;
    logic [15:0] e_data;

    always @(negedge clk) begin
        logic        g0, g1, ld, mw, wr;
        logic [4:0]  a;
        logic [15:0] v;
        logic [2:0]  r;
        if (rst) begin
            for (int i = 0; i < 32; i++) ref_mem[i] <= init_word(i);
            owe1 <= 1'b0;
            e_valid <= 1'b0; e_lane <= 1'b0; e_we <= 1'b0;
            e_reg <= '0; e_data <= '0;
        end else if (rand_on) begin
            chk("wb_valid", wb_valid, e_valid);
            chk("wb_we", wb_we, e_we);
            chk("wb_lane", wb_lane, e_lane);
            chk("wb_reg", wb_reg, e_reg);
            chk("wb_data", wb_data, e_data);
            g0 = !flush && !owe1 && l0_valid;
            g1 = !flush && l1_valid && (owe1 || !l0_valid);
            a = '0; v = '0; ld = 1'b0; mw = 1'b0; wr = 1'b0; r = '0;
            if (g0) begin
                a = l0_addr; v = l0_value; ld = l0_is_load;
                mw = l0_is_mem_write; wr = l0_is_write; r = l0_reg;
            end else if (g1) begin
                a = l1_addr; v = l1_value; ld = l1_is_load;
                mw = l1_is_mem_write; wr = l1_is_write; r = l1_reg;
            end
            chk("l0_ready", l0_ready, g0);
            chk("l1_ready", l1_ready, g1);
            chk("mem_we", mem_we, mw);
            chk("mem_addr", mem_addr, a);
            chk("mem_wdata", mem_wdata, v);
            owe1 <= !flush && !owe1 && l0_valid && l1_valid;
            if (g0 || g1) begin
                e_valid <= 1'b1;
                e_lane  <= g1;
                e_reg   <= r;
                e_we    <= wr;
                e_data  <= (ld && !mw) ? ref_mem[a] : v;
                if (mw) ref_mem[a] <= v;
            end else begin
                e_valid <= 1'b0;
                e_we    <= 1'b0;
            end
        end
    end

    initial begin
        logic r0, r1;
        rst = 1'b1;
        flush = 1'b0;
        drive(0, 1'b1, 5'd9, 16'h7777, 1'b0, 1'b1, 1'b1, 3'd2);
        idle(1);
        #3;
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_wb_data", wb_data, 16'h0);
        chk("rst_l0_ready", l0_ready, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        idle(0);
        @(negedge clk);
        rst = 1'b0;
        tick;

        // store then dependent load through the same port
        drive(0, 1'b1, 5'd5, 16'h1234, 1'b0, 1'b1, 1'b0, 3'd0);
        drive(1, 1'b1, 5'd5, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd3);
        @(negedge clk);
        chk("st_l0_ready", l0_ready, 1'b1);
        chk("st_l1_ready", l1_ready, 1'b0);
        chk("st_mem_we", mem_we, 1'b1);
        chk("st_mem_addr", mem_addr, 5'd5);
        chk("st_mem_wdata", mem_wdata, 16'h1234);
        tick;
        idle(0);
        @(negedge clk);
        chk("ld_l1_ready", l1_ready, 1'b1);
        chk("ld_mem_we", mem_we, 1'b0);
        tick;
        idle(1);
        chk("ld_wb_data", wb_data, 16'h1234);
        chk("ld_wb_reg", wb_reg, 3'd3);
        chk("ld_wb_lane", wb_lane, 1'b1);
        chk("ld_wb_we", wb_we, 1'b1);

        // both lanes, pass-through, in program order
        drive(0, 1'b1, 5'd1, 16'h00AA, 1'b0, 1'b0, 1'b1, 3'd1);
        drive(1, 1'b1, 5'd2, 16'h00BB, 1'b0, 1'b0, 1'b1, 3'd2);
        @(negedge clk);
        chk("pt1_l0_ready", l0_ready, 1'b1);
        chk("pt1_l1_ready", l1_ready, 1'b0);
        tick;
        idle(0);
        chk("pt1_wb_data", wb_data, 16'h00AA);
        chk("pt1_wb_reg", wb_reg, 3'd1);
        @(negedge clk);
        chk("pt2_l0_ready", l0_ready, 1'b0);
        chk("pt2_l1_ready", l1_ready, 1'b1);
        tick;
        idle(1);
        chk("pt2_wb_data", wb_data, 16'h00BB);
        chk("pt2_wb_lane", wb_lane, 1'b1);

        // lane 0 stays valid during HOLD1 and must wait
        drive(0, 1'b1, 5'd3, 16'h0011, 1'b0, 1'b0, 1'b1, 3'd1);
        drive(1, 1'b1, 5'd4, 16'h0022, 1'b0, 1'b0, 1'b1, 3'd2);
        tick;
        drive(0, 1'b1, 5'd6, 16'h00CC, 1'b0, 1'b0, 1'b1, 3'd4);
        @(negedge clk);
        chk("h1_l0_ready", l0_ready, 1'b0);
        chk("h1_l1_ready", l1_ready, 1'b1);
        tick;
        idle(1);
        @(negedge clk);
        chk("h1_l0_next", l0_ready, 1'b1);
        tick;
        idle(0);
        chk("h1_wb_data", wb_data, 16'h00CC);

        // flush while lane 1 is held
        drive(0, 1'b1, 5'd7, 16'h0033, 1'b0, 1'b1, 1'b1, 3'd1);
        drive(1, 1'b1, 5'd8, 16'h0044, 1'b0, 1'b1, 1'b1, 3'd2);
        tick;
        drive(0, 1'b1, 5'd10, 16'h0055, 1'b0, 1'b0, 1'b1, 3'd5);
        flush = 1'b1;
        @(negedge clk);
        chk("fl_l0_ready", l0_ready, 1'b0);
        chk("fl_l1_ready", l1_ready, 1'b0);
        chk("fl_mem_we", mem_we, 1'b0);
        tick;
        flush = 1'b0;
        chk("fl_wb_valid", wb_valid, 1'b0);
        chk("fl_wb_we", wb_we, 1'b0);
        @(negedge clk);
        chk("fl_idle_l0", l0_ready, 1'b1);
        tick;
        idle(0);
        tick;
        idle(1);

        // load from the top word without register write
        drive(0, 1'b1, 5'd31, 16'h0000, 1'b1, 1'b0, 1'b0, 3'd5);
        tick;
        idle(0);
        chk("top_wb_valid", wb_valid, 1'b1);
        chk("top_wb_we", wb_we, 1'b0);
        chk("top_wb_data", wb_data, 16'h4545);

        // asynchronous reset while lane 1 is held
        drive(0, 1'b1, 5'd1, 16'h0066, 1'b0, 1'b0, 1'b1, 3'd6);
        drive(1, 1'b1, 5'd2, 16'h0077, 1'b0, 1'b0, 1'b1, 3'd7);
        tick;
        chk("ar_wb_pre", wb_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("ar_wb_valid", wb_valid, 1'b0);
        chk("ar_wb_data", wb_data, 16'h0);
        chk("ar_wb_reg", wb_reg, 3'd0);
        chk("ar_wb_we", wb_we, 1'b0);
        chk("ar_l1_ready", l1_ready, 1'b0);
        rst = 1'b0;
        idle(0);
        idle(1);
        @(negedge clk);
        chk("ar_no_grant", l1_ready, 1'b0);
        tick;
        chk("ar_wb_after", wb_valid, 1'b0);

        // randomized traffic against the reference model
        rst = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;
        rand_on = 1'b1;
        repeat (2000) begin
            @(negedge clk);
            r0 = l0_ready;
            r1 = l1_ready;
            @(posedge clk);
            #1;
            if (!l0_valid || r0) begin
                if ($urandom_range(0, 2) != 0) rand_lane(0);
                else idle(0);
            end
            if (!l1_valid || r1) begin
                if ($urandom_range(0, 2) != 0) rand_lane(1);
                else idle(1);
            end
            flush = ($urandom_range(0, 15) == 0);
        end
        @(negedge clk);
        rand_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
